// File: rtl/riscv_lsu_pkg.sv
// Shared load/store definitions: access size codes and
// helpers for legality, byte-enable and store-data alignment.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int BE_W = 4;

  function automatic logic is_legal(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (size)
      LDST_B, LDST_BU: ok = 1'b1;
      LDST_H, LDST_HU: ok = ~off[0];
      LDST_W:          ok = (off == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [BE_W-1:0] be_of(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic [BE_W-1:0] be;
    be = '0;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = 4'b0011 << off;
      LDST_W:          be = 4'b1111;
      default:         be = '0;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [2:0]  size,
    input logic [31:0] data
  );
    logic [31:0] wd;
    wd = data;
    case (size)
      LDST_B, LDST_BU: wd = {4{data[7:0]}};
      LDST_H, LDST_HU: wd = {2{data[15:0]}};
      default:         wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// Load data lane select and sign/zero extension from the
// read word, byte offset and access size.
module riscv_lsu_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[8*off +: 8];
    h    = off[1] ? rdata[31:16] : rdata[15:0];
    data = '0;
    case (size)
      LDST_B:  data = {{24{b[7]}}, b};
      LDST_BU: data = {24'b0, b};
      LDST_H:  data = {{16{h[15]}}, h};
      LDST_HU: data = {16'b0, h};
      LDST_W:  data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: aligns requests, runs the req/gnt/rvalid
// handshake with data memory and stalls the core meanwhile.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  state_e      state, state_n;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        legal, start, done;
  logic [31:0] ext;

  assign legal = is_legal(lsu_size_i, lsu_addr_i[1:0]);
  assign start = lsu_req_i & legal;
  assign done  = (state == ST_RESP) & data_rvalid_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state  <= ST_IDLE;
      we_q   <= 1'b0;
      size_q <= 3'd0;
      off_q  <= 2'd0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start) begin
        we_q   <= lsu_we_i;
        size_q <= lsu_size_i;
        off_q  <= lsu_addr_i[1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:
        if (start)
          state_n = data_gnt_i ? ST_RESP : ST_REQ;
      ST_REQ:
        if (data_gnt_i) state_n = ST_RESP;
      ST_RESP:
        if (data_rvalid_i) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  riscv_lsu_extend u_extend (
    .rdata (data_rdata_i),
    .off   (off_q),
    .size  (size_q),
    .data  (ext)
  );

  // Every output is forced low while reset is held, including
  // the purely combinational request path from the core.
  always_comb begin
    data_req_o = arstn_i &
      (((state == ST_IDLE) & start) | (state == ST_REQ));
    data_we_o    = data_req_o & lsu_we_i;
    data_be_o    = data_req_o ?
      be_of(lsu_size_i, lsu_addr_i[1:0]) : 4'b0000;
    data_addr_o  = arstn_i ?
      {lsu_addr_i[31:2], 2'b00} : 32'd0;
    data_wdata_o = arstn_i ?
      wdata_of(lsu_size_i, lsu_data_i) : 32'd0;
    lsu_stall_req_o  = arstn_i & start & ~done;
    lsu_misaligned_o = arstn_i & lsu_req_i & ~legal;
    lsu_data_o = (arstn_i & done & ~we_q) ? ext : 32'd0;
  end

endmodule
